vga_scan_out: RTL and testbench
===============================

// Module: vga_scan_out
// PURPOSE
//  Pixel-timing end of the game's VGA display path (640x480@60). Owns H/V scan counters,
//  presents next_x/next_y to the game's pixel-colour source and samples that source's
//  registered 8-bit colour (RRRGGGBB) one cycle later. Expands colour to 24-bit RGB and
//  emits sync/blank aligned to it for the DAC. Also exports a frame_start strobe for game-tick logic.
// PARAMETERS
//  H_ACTIVE 640  visible pixels/line     | H_FP 16 | H_SYNC 96 | H_BP 48  (H_TOTAL=800)
//  V_ACTIVE 480  visible lines/frame     | V_FP 10 | V_SYNC 2  | V_BP 33  (V_TOTAL=525)
// PORTS
//  clk          in   1   system clock
//  rst          in   1   synchronous reset, active-high
//  ce           in   1   pixel enable (tie 1 at 25 MHz; 1-of-2 at 50 MHz)
//  color_in     in   8   pixel colour {R[2:0],G[2:0],B[1:0]} for coords shown last ce cycle
//  next_x       out  10  horizontal coordinate being requested (0..H_TOTAL-1)
//  next_y       out  10  vertical coordinate being requested (0..V_TOTAL-1)
//  hsync        out  1   horizontal sync, active-low
//  vsync        out  1   vertical sync, active-low
//  red          out  8   DAC red
//  green        out  8   DAC green
//  blue         out  8   DAC blue
//  blank_n      out  1   1 = active video
//  sync_n       out  1   composite sync to DAC, constant 0
//  frame_start  out  1   1-cycle strobe when counters wrap to (0,0)
// BEHAVIOUR
//  - All state advances only on clk edges with ce=1; ce=0 holds every register and output.
//  - Reset (rst=1 at edge, overrides ce): h_cnt=v_cnt=0, hsync=1, vsync=1, blank_n=0,
//    red=green=blue=0, frame_start=0. Reset mid-frame abandons the frame; the first cycle
//    after release presents (0,0) with no frame_start.
//  - Stage 0 (counters): next_x=h_cnt, next_y=v_cnt, driven directly from regs, 10-bit unsigned.
//    h_cnt==H_TOTAL-1 -> h_cnt=0, v_cnt+1; additionally v_cnt==V_TOTAL-1 -> v_cnt=0.
//    Coordinates outside the visible area are still presented; the source may return anything.
//  - Stage 1: source's registered response appears on color_in; sampled together with
//    stage-0 delayed timing flags (active, hs, vs).
//  - Stage 2 (outputs): registered. Total latency next_x/next_y -> RGB/sync/blank = 2 ce cycles.
//  - active = (h<H_ACTIVE)&&(v<V_ACTIVE); blank_n=active.
//  - hs low for h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] = [656,751].
//  - vs low for v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] = [490,491]; whole lines.
//  - Expansion: red={R,R,R[2:1]}, green={G,G,G[2:1]}, blue={B,B,B,B}; all 0 when !active.
//  - frame_start: registered; 1 for exactly one ce cycle in the stage-0 cycle where
//    (h,v)=(0,0) is first presented after wrap from (799,524); aligned with next_x/next_y.
//  - No other handshake: source must return colour within one ce cycle, no back-pressure.
// TESTING
//  1 rst 1->0, ce=1: next_x counts 0..799 then 0 with next_y+1; first hsync fall at
//    cycle 658 after release, low 96 cycles, period 800.
//  2 Run 1 frame: vsync low for 1600 cycles from line 490 (+2 cycle lag); frame_start
//    pulses every 420000 cycles, never on the first (0,0) after reset.
//  3 Source returns 8'b101_011_10 for (10,10) -> 2 cycles later red=B6 green=6D blue=AA, blank_n=1.
//  4 color_in=FF held constant: at x=640..799 and y>=480 RGB=0, blank_n=0.
//  5 ce toggles 1,0,1,0: outputs change only after ce=1 edges; hsync period 1600 clk.
//  6 Assert rst 1 cycle at (300,200): all outputs at reset values; next cycle next_x=next_y=0;
//    next frame_start exactly 420000 ce cycles after release.

Source files
------------

// File: rtl/vga_scan_out.sv
// vga_scan_out: pixel-timing end of the VGA display path.
// Scan counters present the coordinate being requested on next_x/next_y; the
// game's colour source answers with a registered byte one pixel later. Timing
// flags are delayed by one stage so they meet that colour, then colour, syncs
// and blank are registered together for the DAC. Latency from a coordinate on
// next_x/next_y to its pixel at the outputs is two ce cycles.
//
// Handshake: there is none. ce qualifies every register (ce=0 holds all
// state); the source must return its colour on the ce cycle after the
// coordinate was presented, and nothing here can stall it.

module vga_scan_out #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ce,
    input  logic [7:0] color_in,
    output logic [9:0] next_x,
    output logic [9:0] next_y,
    output logic       hsync,
    output logic       vsync,
    output logic [7:0] red,
    output logic [7:0] green,
    output logic [7:0] blue,
    output logic       blank_n,
    output logic       sync_n,
    output logic       frame_start
);

    // Line and frame geometry, sized to the 10-bit counters.
    localparam logic [9:0] H_ACT    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_FIRST = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_LAST  = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_ACT    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_FIRST = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_LAST  = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Stage 0: scan counters
    logic [9:0] h_cnt;
    logic [9:0] v_cnt;
    logic       h_last;
    logic       v_last;

    // Stage 0 timing decode of the coordinate currently presented
    logic       s0_active;
    logic       s0_hs;
    logic       s0_vs;

    // Stage 1: timing flags waiting for the source's colour
    logic       s1_active;
    logic       s1_hs;
    logic       s1_vs;

    // Colour expansion of the byte returned by the source
    logic [2:0] col_r;
    logic [2:0] col_g;
    logic [1:0] col_b;
    logic [7:0] red_exp;
    logic [7:0] green_exp;
    logic [7:0] blue_exp;

    assign h_last = (h_cnt == H_LAST);
    assign v_last = (v_cnt == V_LAST);

    // The requested coordinate is the counter state itself, no extra delay.
    assign next_x = h_cnt;
    assign next_y = v_cnt;

    // The DAC composite sync input is unused in this system.
    assign sync_n = 1'b0;

    // Advance the horizontal counter every pixel and the vertical one at end of line.
    always_ff @(posedge clk) begin
        if (rst) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (ce) begin
            if (h_last) begin
                h_cnt <= '0;
                if (v_last) begin
                    v_cnt <= '0;
                end else begin
                    v_cnt <= v_cnt + 10'd1;
                end
            end else begin
                h_cnt <= h_cnt + 10'd1;
            end
        end
    end

    // Strobe for one ce cycle while (0,0) is presented after a natural wrap;
    // the (0,0) that follows reset does not count as a new frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_start <= 1'b0;
        end else if (ce) begin
            frame_start <= h_last && v_last;
        end
    end

    // Decode visibility and sync windows for the coordinate being requested.
    always_comb begin
        s0_active = 1'b0;
        s0_hs     = 1'b1;
        s0_vs     = 1'b1;
        if ((h_cnt < H_ACT) && (v_cnt < V_ACT)) begin
            s0_active = 1'b1;
        end
        if ((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST)) begin
            s0_hs = 1'b0;
        end
        if ((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST)) begin
            s0_vs = 1'b0;
        end
    end

    // Hold the timing flags for one pixel so they line up with the source's colour.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_active <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
        end else if (ce) begin
            s1_active <= s0_active;
            s1_hs     <= s0_hs;
            s1_vs     <= s0_vs;
        end
    end

    // Replicate the high bits of each field so full scale maps to 8'hFF.
    always_comb begin
        col_r     = color_in[7:5];
        col_g     = color_in[4:2];
        col_b     = color_in[1:0];
        red_exp   = {col_r, col_r, col_r[2:1]};
        green_exp = {col_g, col_g, col_g[2:1]};
        blue_exp  = {col_b, col_b, col_b, col_b};
    end

    // Register colour, syncs and blank together; colour is forced black outside the visible area.
    always_ff @(posedge clk) begin
        if (rst) begin
            hsync   <= 1'b1;
            vsync   <= 1'b1;
            blank_n <= 1'b0;
            red     <= '0;
            green   <= '0;
            blue    <= '0;
        end else if (ce) begin
            hsync   <= s1_hs;
            vsync   <= s1_vs;
            blank_n <= s1_active;
            red     <= s1_active ? red_exp   : 8'h00;
            green   <= s1_active ? green_exp : 8'h00;
            blue    <= s1_active ? blue_exp  : 8'h00;
        end
    end

endmodule

// File: tb/tb_vga_scan_out.sv
// tb_vga_scan_out: directed bench for vga_scan_out.
// Horizontal timing is the real 800-pixel line. The vertical geometry is
// shortened (16 visible lines, sync on lines 18..19, 23 lines per frame) so a
// whole frame fits in 18400 cycles; all vertical expectations use these values.

module tb_vga_scan_out;

    localparam int H_TOTAL = 800;
    localparam int VA      = 16;
    localparam int VF      = 2;
    localparam int VS      = 2;
    localparam int VB      = 3;
    localparam int V_TOTAL = VA + VF + VS + VB;
    localparam int FRAME   = H_TOTAL * V_TOTAL;
    localparam logic [26:0] RESET_EXP = {1'b1, 1'b1, 1'b0, 24'h000000};

    logic       clk = 1'b0;
    logic       rst;
    logic       ce;
    logic [7:0] color_in;
    logic [9:0] next_x;
    logic [9:0] next_y;
    logic       hsync;
    logic       vsync;
    logic [7:0] red;
    logic [7:0] green;
    logic [7:0] blue;
    logic       blank_n;
    logic       sync_n;
    logic       frame_start;

    int n_checks = 0;
    int n_fail   = 0;
    int n        = 0;   // ce cycles since the last reset edge
    int cyc      = 0;   // clk cycles
    int src_mode = 0;

    logic [26:0] exp_q[$];
    logic [26:0] cur_exp = RESET_EXP;

    vga_scan_out #(
        .H_ACTIVE(640), .H_FP(16), .H_SYNC(96), .H_BP(48),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB)
    ) dut (
        .clk(clk), .rst(rst), .ce(ce), .color_in(color_in),
        .next_x(next_x), .next_y(next_y), .hsync(hsync), .vsync(vsync),
        .red(red), .green(green), .blue(blue), .blank_n(blank_n),
        .sync_n(sync_n), .frame_start(frame_start)
    );

    // Clock
    always #5 clk = ~clk;

    // Colour source behaviour: mode 1 is solid white, mode 0 a coordinate pattern
    // with a fixed colour at (10,10).
    function automatic logic [7:0] src(input logic [9:0] x, input logic [9:0] y);
        if (src_mode == 1) return 8'hFF;
        if (x == 10'd10 && y == 10'd10) return 8'b101_011_10;
        return x[7:0] ^ {y[4:0], 3'b000};
    endfunction

    // Expected {hsync, vsync, blank_n, red, green, blue} for one coordinate.
    function automatic logic [26:0] model(input int x, input int y);
        logic [7:0] c;
        logic act, hs, vs;
        logic [7:0] r, g, b;
        c   = src(10'(x), 10'(y));
        act = (x < 640) && (y < VA);
        hs  = !((x >= 656) && (x <= 751));
        vs  = !((y >= 18) && (y <= 19));
        r   = act ? {c[7:5], c[7:5], c[7:6]} : 8'h00;
        g   = act ? {c[4:2], c[4:2], c[4:3]} : 8'h00;
        b   = act ? {c[1:0], c[1:0], c[1:0], c[1:0]} : 8'h00;
        return {hs, vs, act, r, g, b};
    endfunction

    function automatic logic [9:0] exp_x();
        return 10'((n % FRAME) % H_TOTAL);
    endfunction

    function automatic logic [9:0] exp_y();
        return 10'((n % FRAME) / H_TOTAL);
    endfunction

    function automatic logic exp_fs();
        return (n > 0) && ((n % FRAME) == 0);
    endfunction

    // Driver: one clk cycle. Acts as the registered colour source and keeps the
    // expected-output pipeline in step with ce and rst.
    task automatic tick();
        logic [9:0] cx, cy;
        logic cc, cr;
        int mx, my;
        cx = next_x;
        cy = next_y;
        cc = ce;
        cr = rst;
        mx = (n % FRAME) % H_TOTAL;
        my = (n % FRAME) / H_TOTAL;
        @(posedge clk);
        #1;
        cyc++;
        if (cc) color_in = src(cx, cy);
        if (cr) begin
            n = 0;
            exp_q.delete();
            cur_exp = RESET_EXP;
        end else if (cc) begin
            exp_q.push_back(model(mx, my));
            if (exp_q.size() > 1) cur_exp = exp_q.pop_front();
            n++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        ce = 1'b0;
        color_in = 8'h00;
        src_mode = 0;
        repeat (3) tick();
        n_checks++;
        if ({next_y, next_x} !== 20'h0) begin
            n_fail++; $display("FAIL reset_coords got=%h exp=00000", {next_y, next_x});
        end
        n_checks++;
        if (hsync !== 1'b1 || vsync !== 1'b1) begin
            n_fail++; $display("FAIL reset_sync got=%b%b exp=11", hsync, vsync);
        end
        n_checks++;
        if (blank_n !== 1'b0) begin
            n_fail++; $display("FAIL reset_blank got=%b exp=0", blank_n);
        end
        n_checks++;
        if ({red, green, blue} !== 24'h0) begin
            n_fail++; $display("FAIL reset_rgb got=%h exp=000000", {red, green, blue});
        end
        n_checks++;
        if (frame_start !== 1'b0) begin
            n_fail++; $display("FAIL reset_frame_start got=%b exp=0", frame_start);
        end
        n_checks++;
        if (sync_n !== 1'b0) begin
            n_fail++; $display("FAIL sync_n got=%b exp=0", sync_n);
        end
        rst = 1'b0;
        ce = 1'b1;
    endtask

    task automatic test_line_scan();
        int first_fall, rise, second_fall;
        logic prev_hs;
        first_fall = -1; rise = -1; second_fall = -1;
        prev_hs = hsync;
        while (n < 1700 && cyc < 5000) begin
            tick();
            n_checks++;
            if ({hsync, vsync, blank_n, red, green, blue} !== cur_exp) begin
                n_fail++; $display("FAIL line_scan_pixel n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, red, green, blue}, cur_exp);
            end
            n_checks++;
            if ({next_y, next_x} !== {exp_y(), exp_x()}) begin
                n_fail++; $display("FAIL line_scan_coords n=%0d got=%0d,%0d exp=%0d,%0d", n, next_x, next_y, exp_x(), exp_y());
            end
            n_checks++;
            if (frame_start !== exp_fs()) begin
                n_fail++; $display("FAIL line_scan_frame_start n=%0d got=%b exp=%b", n, frame_start, exp_fs());
            end
            if (prev_hs && !hsync) begin
                if (first_fall < 0) first_fall = n;
                else if (second_fall < 0) second_fall = n;
            end
            if (!prev_hs && hsync && rise < 0) rise = n;
            prev_hs = hsync;
        end
        n_checks++;
        if (first_fall != 658) begin
            n_fail++; $display("FAIL hsync_first_fall got=%0d exp=658", first_fall);
        end
        n_checks++;
        if (rise - first_fall != 96) begin
            n_fail++; $display("FAIL hsync_low_width got=%0d exp=96", rise - first_fall);
        end
        n_checks++;
        if (second_fall - first_fall != 800) begin
            n_fail++; $display("FAIL hsync_period got=%0d exp=800", second_fall - first_fall);
        end
    endtask

    task automatic test_color_pipeline();
        while (n < 8012 && cyc < 12000) begin
            tick();
            n_checks++;
            if ({hsync, vsync, blank_n, red, green, blue} !== cur_exp) begin
                n_fail++; $display("FAIL color_pixel n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, red, green, blue}, cur_exp);
            end
            n_checks++;
            if ({next_y, next_x} !== {exp_y(), exp_x()}) begin
                n_fail++; $display("FAIL color_coords n=%0d got=%0d,%0d exp=%0d,%0d", n, next_x, next_y, exp_x(), exp_y());
            end
        end
        // (10,10) was presented at n=8010, so its pixel is out now
        n_checks++;
        if ({red, green, blue} !== 24'hB66DAA) begin
            n_fail++; $display("FAIL color_expand got=%h exp=B66DAA", {red, green, blue});
        end
        n_checks++;
        if (blank_n !== 1'b1) begin
            n_fail++; $display("FAIL color_blank got=%b exp=1", blank_n);
        end
    endtask

    task automatic test_blanking();
        int k, q, x, y;
        src_mode = 1;
        k = 0;
        while (n < 14000 && cyc < 20000) begin
            tick();
            k++;
            n_checks++;
            if ({hsync, vsync, blank_n, red, green, blue} !== cur_exp) begin
                n_fail++; $display("FAIL blank_pixel n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, red, green, blue}, cur_exp);
            end
            if (k >= 3) begin
                q = n - 2;
                x = q % H_TOTAL;
                y = q / H_TOTAL;
                n_checks++;
                if (x >= 640 || y >= VA) begin
                    if ({blank_n, red, green, blue} !== 25'h0) begin
                        n_fail++; $display("FAIL blank_region x=%0d y=%0d got=%h exp=0", x, y, {blank_n, red, green, blue});
                    end
                end else begin
                    if ({blank_n, red, green, blue} !== 25'h1FFFFFF) begin
                        n_fail++; $display("FAIL white_region x=%0d y=%0d got=%h exp=1ffffff", x, y, {blank_n, red, green, blue});
                    end
                end
            end
        end
        src_mode = 0;
    endtask

    task automatic test_vsync_frame();
        int vs_fall, vs_rise, fs_count, fs_n;
        logic prev_vs;
        vs_fall = -1; vs_rise = -1; fs_count = 0; fs_n = -1;
        prev_vs = vsync;
        while (n < FRAME + 5 && cyc < 30000) begin
            tick();
            n_checks++;
            if ({hsync, vsync, blank_n, red, green, blue} !== cur_exp) begin
                n_fail++; $display("FAIL frame_pixel n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, red, green, blue}, cur_exp);
            end
            n_checks++;
            if ({next_y, next_x} !== {exp_y(), exp_x()}) begin
                n_fail++; $display("FAIL frame_coords n=%0d got=%0d,%0d exp=%0d,%0d", n, next_x, next_y, exp_x(), exp_y());
            end
            if (prev_vs && !vsync && vs_fall < 0) vs_fall = n;
            if (!prev_vs && vsync && vs_rise < 0) vs_rise = n;
            prev_vs = vsync;
            if (frame_start === 1'b1) begin
                fs_count++;
                fs_n = n;
            end
        end
        n_checks++;
        if (vs_fall != 14402) begin
            n_fail++; $display("FAIL vsync_fall got=%0d exp=14402", vs_fall);
        end
        n_checks++;
        if (vs_rise - vs_fall != 1600) begin
            n_fail++; $display("FAIL vsync_low_width got=%0d exp=1600", vs_rise - vs_fall);
        end
        n_checks++;
        if (fs_count != 1 || fs_n != FRAME) begin
            n_fail++; $display("FAIL frame_start_pulse count=%0d at=%0d exp count=1 at=%0d", fs_count, fs_n, FRAME);
        end
    endtask

    task automatic test_ce_throttle();
        int f1, f2;
        logic prev_hs;
        f1 = -1; f2 = -1;
        prev_hs = hsync;
        for (int i = 0; i < 3600; i++) begin
            ce = (i % 2 == 0);
            tick();
            n_checks++;
            if ({hsync, vsync, blank_n, red, green, blue} !== cur_exp) begin
                n_fail++; $display("FAIL ce_pixel cyc=%0d got=%h exp=%h", cyc, {hsync, vsync, blank_n, red, green, blue}, cur_exp);
            end
            n_checks++;
            if ({next_y, next_x} !== {exp_y(), exp_x()}) begin
                n_fail++; $display("FAIL ce_coords cyc=%0d got=%0d,%0d exp=%0d,%0d", cyc, next_x, next_y, exp_x(), exp_y());
            end
            n_checks++;
            if (frame_start !== exp_fs()) begin
                n_fail++; $display("FAIL ce_frame_start cyc=%0d got=%b exp=%b", cyc, frame_start, exp_fs());
            end
            if (prev_hs && !hsync) begin
                if (f1 < 0) f1 = cyc;
                else if (f2 < 0) f2 = cyc;
            end
            prev_hs = hsync;
        end
        ce = 1'b1;
        n_checks++;
        if (f2 - f1 != 1600) begin
            n_fail++; $display("FAIL ce_hsync_period got=%0d exp=1600", f2 - f1);
        end
    endtask

    task automatic test_reset_midframe();
        int guard, cnt;
        guard = 0;
        while ((n % FRAME) != 12 * H_TOTAL + 300 && guard < FRAME + 10) begin
            tick();
            guard++;
        end
        n_checks++;
        if ({next_y, next_x} !== {10'd12, 10'd300}) begin
            n_fail++; $display("FAIL midframe_position got=%0d,%0d exp=300,12", next_x, next_y);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++;
        if ({next_y, next_x} !== 20'h0) begin
            n_fail++; $display("FAIL midframe_reset_coords got=%0d,%0d exp=0,0", next_x, next_y);
        end
        n_checks++;
        if ({hsync, vsync, blank_n, red, green, blue} !== RESET_EXP || frame_start !== 1'b0) begin
            n_fail++; $display("FAIL midframe_reset_outputs got=%h fs=%b exp=%h fs=0", {hsync, vsync, blank_n, red, green, blue}, frame_start, RESET_EXP);
        end
        cnt = 0;
        while (frame_start !== 1'b1 && cnt < FRAME + 10) begin
            tick();
            cnt++;
            n_checks++;
            if ({hsync, vsync, blank_n, red, green, blue} !== cur_exp) begin
                n_fail++; $display("FAIL midframe_pixel n=%0d got=%h exp=%h", n, {hsync, vsync, blank_n, red, green, blue}, cur_exp);
            end
            n_checks++;
            if ({next_y, next_x} !== {exp_y(), exp_x()}) begin
                n_fail++; $display("FAIL midframe_coords n=%0d got=%0d,%0d exp=%0d,%0d", n, next_x, next_y, exp_x(), exp_y());
            end
        end
        n_checks++;
        if (cnt != FRAME) begin
            n_fail++; $display("FAIL midframe_frame_start_delay got=%0d exp=%0d", cnt, FRAME);
        end
    endtask

    initial begin
        rst = 1'b1;
        ce = 1'b0;
        color_in = 8'h00;
        test_reset();
        test_line_scan();
        test_color_pipeline();
        test_blanking();
        test_vsync_frame();
        test_ce_throttle();
        test_reset_midframe();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
